noise_lut_injector: RTL and testbench

//  Adds table-shaped random noise to a signed 8-bit sample stream in the SERDES channel model.
//  A 128-entry table of 64-bit cumulative-distribution thresholds is first loaded from memory.
//  A 64-bit LFSR is then compared against every threshold; the hit count selects the noise value.

---
 rtl/noise_pkg.sv | 35 +++
 rtl/noise_popcount.sv | 36 +++
 rtl/noise_lut_injector.sv | 202 ++++++++++++++++++++
 tb/tb_noise_lut_injector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// -----------------------------------------------------------------------------
// noise_pkg
// Shared constants, types and the LFSR step function for the table-shaped
// noise injector (noise_lut_injector) and its popcount sub-module.
//   DEPTH     number of cumulative-distribution thresholds in the table
//   DATA_W    signed sample width
//   THRESH_W  threshold and LFSR width
//   CNT_W     width of a hit count in 0..DEPTH
//   SUM_W     working width of sample + noise before reduction to DATA_W
// -----------------------------------------------------------------------------
package noise_pkg;

    localparam int DEPTH    = 128;
    localparam int DATA_W   = 8;
    localparam int THRESH_W = 64;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int CNT_W    = ADDR_W + 1;
    localparam int SUM_W    = DATA_W + 2;

    typedef logic [THRESH_W-1:0]      thresh_t;
    typedef logic signed [DATA_W-1:0] sample_t;

    // Default LFSR reset value; an all-zero state would lock the LFSR up.
    localparam thresh_t LFSR_SEED = 64'hACE1_2468_1357_BDF9;

    // Feedback taps 64,63,61,60 (numbered from 1) expressed as bit positions
    // 63,62,60,59 of the state vector.
    localparam thresh_t LFSR_TAPS = 64'hD800_0000_0000_0000;

    // One Fibonacci step: shift towards the MSB, feedback enters at bit 0.
    function automatic thresh_t lfsr_step(input thresh_t cur);
        return {cur[THRESH_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/noise_popcount.sv
// -----------------------------------------------------------------------------
// noise_popcount
// Purely combinational population count of the threshold-compare vector.
// Ports:
//   cmp_i    in   DEPTH   one bit per table entry, 1 = threshold below LFSR
//   count_o  out  CNT_W   number of set bits, 0..DEPTH
// -----------------------------------------------------------------------------
module noise_popcount
    import noise_pkg::*;
(
    input  logic [DEPTH-1:0] cmp_i,
    output logic [CNT_W-1:0] count_o
);

    // Sum per 8-bit group first so the adder tree stays shallow and regular.
    localparam int GROUPS = DEPTH / 8;

    logic [3:0] group_cnt [GROUPS];

    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            group_cnt[g] = '0;
            for (int b = 0; b < 8; b++) begin
                group_cnt[g] = group_cnt[g] + 4'(cmp_i[g*8 + b]);
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int g = 0; g < GROUPS; g++) begin
            count_o = count_o + CNT_W'(group_cnt[g]);
        end
    end

endmodule

// File: rtl/noise_lut_injector.sv
// -----------------------------------------------------------------------------
// noise_lut_injector
// Adds table-shaped random noise to a signed sample stream. A table of DEPTH
// cumulative-distribution thresholds is loaded first; afterwards every
// accepted sample compares the LFSR against all thresholds, and the number of
// thresholds strictly below the LFSR, minus DEPTH/2, is the noise added.
//
// Build option:
//   NOISE_SAT_EN defined   -> sample + noise clamps to the signed DATA_W range
//   NOISE_SAT_EN undefined -> sample + noise wraps to its low DATA_W bits
//
// Ports:
//   clk              in   1        rising-edge clock
//   rstn             in   1        asynchronous active-low reset
//   en               in   1        global enable; 0 freezes all state
//   load_mem         in   1        table write strobe
//   location         in   8        write address, bits [6:0] used
//   mem_data         in   64       threshold to write
//   done_wait        out  1        DEPTH writes seen; generation allowed
//   noise_in         in   DATA_W   signed input sample
//   noise_in_valid   in   1        noise_in valid this cycle
//   noise_out        out  DATA_W   signed sample plus noise
//   noise_out_valid  out  1        noise_out valid this cycle
//
// Pipeline: accept -> stage 1 (compare vector, sample) -> stage 2 (popcount,
// add, reduce) registered into noise_out; valid two cycles after accept.
// -----------------------------------------------------------------------------
module noise_lut_injector
    import noise_pkg::*;
#(
    parameter thresh_t SEED = LFSR_SEED
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              load_mem,
    input  logic [7:0]        location,
    input  logic [63:0]       mem_data,
    output logic              done_wait,
    input  logic [DATA_W-1:0] noise_in,
    input  logic              noise_in_valid,
    output logic [DATA_W-1:0] noise_out,
    output logic              noise_out_valid
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    thresh_t          thresh_q [DEPTH];
    logic [CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
    logic             done_q,      done_d;
    thresh_t          lfsr_q,      lfsr_d;
    logic [DEPTH-1:0] cmp_q,       cmp_d;
    sample_t          s1_data_q,   s1_data_d;
    logic             s1_valid_q,  s1_valid_d;
    sample_t          out_q,       out_d;
    logic             out_valid_q, out_valid_d;

    logic [DEPTH-1:0]        cmp_now;
    logic                    accept;
    logic [CNT_W-1:0]        hit_cnt;
    logic signed [SUM_W-1:0] noise_s;
    logic signed [SUM_W-1:0] sum_s;
    sample_t                 sum_red;

    // The address MSB is outside the table range and intentionally ignored.
    logic unused_location_msb;
    assign unused_location_msb = location[7];

    assign accept = en & done_q & noise_in_valid;

    // -------------------------------------------------------------------------
    // Threshold table
    // -------------------------------------------------------------------------
    // NOTE: the table is held in flops with an asynchronous clear because it
    // must read as all-zero straight out of reset; a plain RAM would not.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                thresh_q[i] <= '0;
            end
        end else if (en && load_mem) begin
            thresh_q[location[ADDR_W-1:0]] <= mem_data;
        end
    end

    // Compare against the registered table, so a write landing on the same
    // edge as an accept is not seen by that sample.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cmp_now[i] = (thresh_q[i] < lfsr_q);
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 arithmetic
    // -------------------------------------------------------------------------
    noise_popcount u_popcount (
        .cmp_i   (cmp_q),
        .count_o (hit_cnt)
    );

    assign noise_s = $signed({{(SUM_W-CNT_W){1'b0}}, hit_cnt})
                   - $signed(SUM_W'(DEPTH / 2));
    assign sum_s   = $signed({{(SUM_W-DATA_W){s1_data_q[DATA_W-1]}}, s1_data_q})
                   + noise_s;

`ifdef NOISE_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(DATA_W-1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(DATA_W-1)));

    always_comb begin
        sum_red = sum_s[DATA_W-1:0];
        if (sum_s > SAT_MAX) begin
            sum_red = SAT_MAX[DATA_W-1:0];
        end else if (sum_s < SAT_MIN) begin
            sum_red = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    // Two's complement wrap: the guard bits are simply dropped.
    logic [SUM_W-DATA_W-1:0] unused_sum_msbs;
    assign unused_sum_msbs = sum_s[SUM_W-1:DATA_W];
    assign sum_red         = sum_s[DATA_W-1:0];
`endif

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts as its _q so each path through the block
        // assigns it; a missing default here would infer a latch.
        wr_cnt_d    = wr_cnt_q;
        done_d      = done_q;
        lfsr_d      = lfsr_q;
        cmp_d       = cmp_q;
        s1_data_d   = s1_data_q;
        s1_valid_d  = s1_valid_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (en) begin
            // Write counter counts strobes, not distinct addresses, and
            // saturates; done is sticky until reset.
            if (load_mem && (wr_cnt_q != CNT_W'(DEPTH))) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == CNT_W'(DEPTH - 1)) begin
                    done_d = 1'b1;
                end
            end

            // Stage 1: the sample uses the current LFSR value; the LFSR
            // then advances so the next sample sees a fresh draw.
            s1_valid_d = accept;
            if (accept) begin
                cmp_d     = cmp_now;
                s1_data_d = noise_in;
                lfsr_d    = lfsr_step(lfsr_q);
            end

            // Stage 2: noise_out keeps its last value between samples.
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = sum_red;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q    <= '0;
            done_q      <= 1'b0;
            lfsr_q      <= SEED;
            cmp_q       <= '0;
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            done_q      <= done_d;
            lfsr_q      <= lfsr_d;
            cmp_q       <= cmp_d;
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // While en is low the output stage is frozen; masking the frozen valid
    // hides it until en returns, when it is presented exactly once.
    assign done_wait       = done_q;
    assign noise_out       = out_q;
    assign noise_out_valid = out_valid_q & en;

endmodule

// File: tb/tb_noise_lut_injector.sv
// -----------------------------------------------------------------------------
// tb_noise_lut_injector
// Self-checking bench for noise_lut_injector. A behavioural model (threshold
// array, LFSR value, write count) predicts each output from the sample rules;
// a negedge monitor checks done_wait every cycle and expects each predicted
// output in the first enabled cycle after its second enabled edge.
// Build with NOISE_SAT_EN defined to check the saturating variant.
// -----------------------------------------------------------------------------
module tb_noise_lut_injector;

    localparam logic [63:0] SEED = 64'hACE1_2468_1357_BDF9;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        load_mem;
    logic [7:0]  location;
    logic [63:0] mem_data;
    logic        done_wait;
    logic [7:0]  noise_in;
    logic        noise_in_valid;
    logic [7:0]  noise_out;
    logic        noise_out_valid;

    noise_lut_injector dut (
        .clk             (clk),
        .rstn            (rstn),
        .en              (en),
        .load_mem        (load_mem),
        .location        (location),
        .mem_data        (mem_data),
        .done_wait       (done_wait),
        .noise_in        (noise_in),
        .noise_in_valid  (noise_in_valid),
        .noise_out       (noise_out),
        .noise_out_valid (noise_out_valid)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ check
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        logic [7:0]  value;
        int unsigned due;
    } exp_t;

    logic [63:0] thresh_m [128];
    logic [63:0] lfsr_m   = SEED;
    int          wr_m     = 0;
    logic        done_m   = 1'b0;
    int unsigned en_edges = 0;
    exp_t        exp_q [$];

    // Taps 64,63,61,60 counted from 1 = state bits 63,62,60,59.
    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        logic fb;
        fb = x[63] ^ x[62] ^ x[60] ^ x[59];
        return {x[62:0], fb};
    endfunction

    function automatic logic [7:0] expect_out(input logic [7:0] din);
        int cnt = 0;
        int s;
        for (int i = 0; i < 128; i++) begin
            if (thresh_m[i] < lfsr_m) cnt++;
        end
        s = int'($signed(din)) + cnt - 64;
`ifdef NOISE_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return 8'(s);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) thresh_m[i] = '0;
        lfsr_m = SEED;
        wr_m   = 0;
        done_m = 1'b0;
        exp_q.delete();
    endfunction

    // Applies one rising edge to the model using the inputs the DUT sees.
    function automatic void model_edge();
        exp_t e;
        if (!rstn || !en) return;
        en_edges++;
        if (done_m && noise_in_valid) begin
            e.value = expect_out(noise_in);
            e.due   = en_edges + 1;
            exp_q.push_back(e);
            lfsr_m  = lfsr_next(lfsr_m);
        end
        if (load_mem) begin
            thresh_m[location[6:0]] = mem_data;
            if (wr_m < 128) wr_m++;
            if (wr_m == 128) done_m = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [63:0] rand_thresh();
        case ($urandom_range(0, 3))
            0:       return 64'd0;
            1:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("done_wait", done_wait, done_m);
            if (rstn && en && exp_q.size() > 0 && exp_q[0].due == en_edges) begin
                e = exp_q.pop_front();
                check("out_valid", noise_out_valid, 1'b1);
                check("out_value", noise_out, e.value);
            end else begin
                check("no_out", noise_out_valid, 1'b0);
            end
        end
    end

    // One isolated sample: checks latency, value and pulse width.
    task automatic send_one(input string tag, input logic [7:0] din, input logic [7:0] want);
        noise_in       = din;
        noise_in_valid = 1'b1;
        tick();
        noise_in_valid = 1'b0;
        check({tag, "_lat1"}, noise_out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, noise_out_valid, 1'b1);
        check({tag, "_value"}, noise_out, want);
        tick();
        check({tag, "_pulse"}, noise_out_valid, 1'b0);
    endtask

    task automatic load_all(input logic [63:0] val, input bit randomize_vals);
        for (int i = 0; i < 128; i++) begin
            load_mem = 1'b1;
            location = 8'(i);
            mem_data = randomize_vals ? rand_thresh() : val;
            tick();
        end
        load_mem = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rstn = 1'b0; en = 1'b0; load_mem = 1'b0; location = '0; mem_data = '0;
        noise_in = '0; noise_in_valid = 1'b0;
        model_reset();

        #12;
        check("rst_done", done_wait, 1'b0);
        check("rst_valid", noise_out_valid, 1'b0);
        check("rst_out", noise_out, 8'd0);
        tick();
        tick();
        rstn = 1'b1;
        en   = 1'b1;

        // T2: samples before the table is loaded are ignored
        noise_in       = 8'd33;
        noise_in_valid = 1'b1;
        repeat (10) begin
            tick();
            check("t2_no_out", noise_out_valid, 1'b0);
        end
        noise_in_valid = 1'b0;

        // T1: 128 writes of zero; done rises on the edge of the last one
        for (int i = 0; i < 128; i++) begin
            load_mem = 1'b1;
            location = 8'(i);
            mem_data = 64'd0;
            tick();
            check("t1_done", done_wait, (i == 127));
        end
        load_mem = 1'b0;

        // T3: all thresholds below the LFSR -> noise +64
        send_one("t3", 8'd10, 8'd74);

        // T5: 100 + 64 exceeds the sample range
`ifdef NOISE_SAT_EN
        send_one("t5", 8'd100, 8'd127);
`else
        send_one("t5", 8'd100, 8'hA4);
`endif

        // T4: live reload with the maximum threshold -> noise -64
        load_all('1, 1'b0);
        check("t4_done_kept", done_wait, 1'b1);
        send_one("t4", 8'hFB, 8'hBB);

        // T6: random table, continuous stream with random live writes,
        // en gap, then asynchronous reset mid-cycle
        load_all('0, 1'b1);
        for (int c = 0; c < 500; c++) begin
            noise_in       = 8'($urandom);
            noise_in_valid = 1'b1;
            en             = !(c >= 200 && c < 203);
            load_mem       = ($urandom_range(0, 9) == 0);
            location       = 8'($urandom);
            mem_data       = rand_thresh();
            if (c == 400) begin
                #2;
                rstn = 1'b0;
                model_reset();
                #1;
                check("t6_rst_done", done_wait, 1'b0);
                check("t6_rst_valid", noise_out_valid, 1'b0);
                check("t6_rst_out", noise_out, 8'd0);
            end
            if (c == 402) rstn = 1'b1;
            tick();
        end
        noise_in_valid = 1'b0;
        load_mem       = 1'b0;
        en             = 1'b1;
        repeat (4) tick();
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
